ppi_commutator_ctrl: RTL

//  Input commutator controller for the polyphase decimator (filt_ppi).
//  - Accepts one input sample per handshake and steers it round-robin into gp_nr_phases branch shift registers.
//  - Counts complete frames until every branch delay line is filled.
//  - Then raises a frame-valid handshake per frame so the branch MAC can compute one decimated output sample.

---
 rtl/ppi_commutator_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ppi_commutator_ctrl.sv
// ppi_commutator_ctrl: input commutator for the polyphase decimator.
// Steers samples round-robin (M-1 down to 0) into the branch shift registers.
// Counts frames until the branch delay lines are full, then hands each frame
// to the branch MAC through a frame-valid handshake.
// Optional: PPI_CTRL_OVF_EN adds a sticky overflow flag (i_ovf_clr / o_ovf).
module ppi_commutator_ctrl #(
  parameter int gp_data_width        = 8,
  parameter int gp_nr_phases         = 4,
  parameter int gp_nr_taps_per_phase = 4,
  localparam int PW = $clog2(gp_nr_phases)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_an,
  input  logic                          i_ena,
  input  logic [gp_data_width-1:0]      i_data,
  input  logic                          i_vld,
  output logic                          o_rdy,
  output logic [gp_data_width-1:0]      o_branch_data,
  output logic [gp_nr_phases-1:0]       o_branch_ena,
  output logic [PW-1:0]                 o_phase,
  output logic                          o_frame_vld,
  input  logic                          i_frame_rdy,
  output logic                          o_fill_done
`ifdef PPI_CTRL_OVF_EN
  ,
  input  logic                          i_ovf_clr,
  output logic                          o_ovf
`endif
);

  localparam int CW = $clog2(gp_nr_taps_per_phase + 1);
  localparam logic [CW-1:0] TCNT  = CW'(gp_nr_taps_per_phase);
  localparam logic [PW-1:0] PHMAX = PW'(gp_nr_phases - 1);

  typedef enum logic [1:0] {ACCEPT, COMMIT, HOLD} state_t;

  state_t                     r_state, w_state_nxt;
  logic [gp_data_width-1:0]   r_data;
  logic [gp_nr_phases-1:0]    r_strb;
  logic [PW-1:0]              r_phase;
  logic [CW-1:0]              r_cnt;
  logic                       r_frame_vld;
  logic                       r_fill_done;
  logic                       w_rdy;
  logic                       w_acc;
  logic [CW-1:0]              w_cnt_inc;
  logic                       w_full;

  // Saturating frame count; w_full means every delay line holds T samples
  assign w_cnt_inc = (r_cnt == TCNT) ? TCNT : r_cnt + CW'(1);
  assign w_full    = (w_cnt_inc == TCNT);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an)  r_state <= ACCEPT;
    else if (i_ena) r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      ACCEPT: begin
        w_rdy = 1'b1;
        w_acc = i_ena & i_vld;
        if (w_acc && r_phase == '0) w_state_nxt = COMMIT;
      end
      COMMIT: w_state_nxt = w_full ? HOLD : ACCEPT;
      HOLD:   if (i_frame_rdy) w_state_nxt = ACCEPT;
      default: w_state_nxt = ACCEPT;
    endcase
  end

  // Sample capture, one-hot strobe and descending phase pointer
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_data  <= '0;
      r_strb  <= '0;
      r_phase <= PHMAX;
    end else if (i_ena) begin
      r_strb <= '0;
      if (w_acc) begin
        r_data          <= i_data;
        r_strb[r_phase] <= 1'b1;
        r_phase         <= (r_phase == '0) ? PHMAX : r_phase - PW'(1);
      end
    end
  end

  // Frame counting and frame-valid handshake towards the MAC
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_cnt       <= '0;
      r_frame_vld <= 1'b0;
      r_fill_done <= 1'b0;
    end else if (i_ena) begin
      if (r_state == COMMIT) begin
        r_cnt <= w_cnt_inc;
        if (w_full) begin
          r_fill_done <= 1'b1;
          r_frame_vld <= 1'b1;
        end
      end else if (r_state == HOLD && i_frame_rdy) begin
        r_frame_vld <= 1'b0;
      end
    end
  end

`ifdef PPI_CTRL_OVF_EN
  logic r_ovf;

  // Sticky overflow: a sample offered while stalled is lost; set beats clear
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) r_ovf <= 1'b0;
    else if (i_ena) begin
      if (i_vld && !w_rdy) r_ovf <= 1'b1;
      else if (i_ovf_clr)  r_ovf <= 1'b0;
    end
  end

  assign o_ovf = r_ovf;
`else
  // No overflow tracking: a sample offered while o_rdy=0 is simply dropped.
`endif

  // Strobe gated by enable so each branch write happens on one enabled edge
  assign o_branch_ena  = r_strb & {gp_nr_phases{i_ena}};
  assign o_branch_data = r_data;
  assign o_phase       = r_phase;
  assign o_rdy         = w_rdy;
  assign o_frame_vld   = r_frame_vld;
  assign o_fill_done   = r_fill_done;

endmodule
